sd_sector_read_ctrl: RTL and testbench
======================================

// Module: sd_sector_read_ctrl
// PURPOSE
//  Single-sector read cache between the CPU data port and the SD host. Holds one 512-byte
//  sector (4096 b) plus its tag. Hits return a 32-bit word from the buffer. Misses sequence an SD
//  sector read, capture the sector, then return the word. Word extraction is bit-reversed.
// PARAMETERS
//  TIMEOUT_CYCLES  1048576  cycles to wait for sd_done before the request fails with cpu_err
//  SECTOR_W        23       sector-number width; cpu_addr[31:9] is the sector, zero-extended onto sd_sector
// PORTS
//  clk          in   1     system clock, all logic on rising edge
//  rst          in   1     reset, synchronous, active-high
//  cpu_req      in   1     read request; level, held until cpu_ack
//  cpu_addr     in   32    byte address: [31:9] sector, [8:2] word index, [1:0] ignored
//  cpu_ack      out  1     one-cycle pulse; cpu_rdata/cpu_err valid this cycle
//  cpu_rdata    out  32    read word
//  cpu_err      out  1     asserted with cpu_ack on SD timeout
//  inv          in   1     one-cycle pulse; invalidates the cached sector
//  sd_rd_start  out  1     one-cycle pulse; starts a read of sd_sector
//  sd_sector    out  32    sector number; stable from sd_rd_start until sd_done or timeout
//  sd_busy      in   1     SD host busy; sd_rd_start is never issued while high
//  sd_done      in   1     one-cycle pulse; sd_data holds the full sector this cycle
//  sd_data      in   4096  sector bits from the SD host
// BEHAVIOUR
//  - Reset: state=IDLE; valid=0; tag=0; buffer not cleared.
//    cpu_ack=0, cpu_err=0, cpu_rdata=0, sd_rd_start=0, sd_sector=0. Timeout counter=0.
//  - FSM states: IDLE, CHECK, ISSUE, WAIT, RESP.
//  - IDLE: on cpu_req, latch sector and word index, go to CHECK. Later cpu_addr changes are ignored.
//  - CHECK: valid && tag==sector -> RESP (hit). Otherwise drive sd_sector, go to ISSUE.
//  - ISSUE: stay while sd_busy=1. When sd_busy=0, pulse sd_rd_start for 1 cycle, clear counter, go to WAIT.
//  - WAIT, on sd_done: capture sd_data into buffer, set tag=sector and valid=1, go to RESP.
//  - WAIT, at counter==TIMEOUT_CYCLES-1 without sd_done: go to RESP with err; valid=0.
//  - RESP: cpu_ack=1 for exactly 1 cycle.
//    Normal: cpu_rdata = selected word, cpu_err=0. Error: cpu_rdata=0, cpu_err=1. Then IDLE.
//  - Latency from cpu_req sampled in IDLE (edge 0): hit -> cpu_ack high after edge 2.
//    Miss -> sd_rd_start high after edge 2 if sd_busy=0; cpu_ack 2 edges after the sd_done edge.
//  - Requester drops cpu_req in the cycle after cpu_ack. If cpu_req is still high in IDLE,
//    it starts a new request (back-to-back allowed).
//  - Word select: word k = buffer[32k +: 32], bit-reversed: cpu_rdata[31-i] = buffer[32k+i], i=0..31.
//    k=0..127; no wrap or out-of-range case.
//  - inv: clears valid on the next edge in any state.
//    inv with sd_done in WAIT: data is still returned to the CPU, but valid stays 0 (inv wins).
//    inv in CHECK forces a miss.
//  - sd_done outside WAIT (late after timeout, or after reset) is ignored; buffer/tag/valid unchanged.
//  - cpu_req while not in IDLE is not sampled. Only one request is outstanding.
//  - Reset mid-operation: immediate return to reset values.
//    An in-flight SD read is abandoned; its sd_done is ignored.
//  - Timeout counter: 20 bits; counts only in WAIT; never wraps, because it exits at TIMEOUT_CYCLES-1.
// STRUCTURE
//  - Package sd_ctrl_pkg: state encoding constants, SECTOR_BITS=4096, WORDS_PER_SECTOR=128,
//    WORD_IDX_W=7, TIMEOUT_W=20.
//  - Sub-module sd_word_select: combinational bit-reversed 32-of-4096 mux (data_in, idx, data_out).
//    cpu_rdata is registered at its output in RESP.
//  - Top: FSM, address/tag/valid regs, 4096-b buffer, timeout counter.
// TESTING
//  - Cold miss: sd_busy=0; req addr 0x0000_0204 -> sd_rd_start 1 cycle, sd_sector=1.
//    sd_data word1 bits = 0x0000_0001 -> cpu_rdata=0x8000_0000, cpu_err=0.
//  - Hit: repeat with addr 0x0000_03FC -> no sd_rd_start; cpu_ack 2 cycles after req; cpu_rdata = reversed word127.
//  - Busy stall: sd_busy=1 for 10 cycles on a miss -> sd_rd_start only in the first cycle with sd_busy=0.
//  - Timeout: TIMEOUT_CYCLES=16, no sd_done -> cpu_ack with cpu_err=1, cpu_rdata=0.
//    Re-request of the same sector misses; a late sd_done is ignored.
//  - inv coincident with sd_done -> data returned; immediate re-request of the same sector
//    issues sd_rd_start again.
//  - rst asserted in WAIT, then sd_done pulse -> no cpu_ack; valid=0; next request misses.

Source files
------------

// File: rtl/sd_ctrl_pkg.sv
// Shared constants and state encoding for the SD single-sector read cache.
package sd_ctrl_pkg;

  localparam int unsigned SECTOR_BITS      = 4096;
  localparam int unsigned WORDS_PER_SECTOR = 128;
  localparam int unsigned WORD_IDX_W       = $clog2(WORDS_PER_SECTOR);
  localparam int unsigned TIMEOUT_W        = 20;
  localparam int unsigned WORD_W           = 32;
  localparam int unsigned ADDR_W           = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/sd_word_select.sv
// Combinational 32-of-4096 word mux with bit reversal of the selected word.
module sd_word_select
  import sd_ctrl_pkg::*;
(
  input  logic [SECTOR_BITS-1:0] data_in,
  input  logic [WORD_IDX_W-1:0]  idx,
  output logic [WORD_W-1:0]      data_out
);

  logic [WORD_W-1:0] word;

  // Pick word idx (bit offset idx*32) and reverse its bit order
  always_comb begin
    word     = data_in[{idx, 5'd0} +: WORD_W];
    data_out = '0;
    for (int i = 0; i < WORD_W; i++) begin
      data_out[WORD_W-1-i] = word[i];
    end
  end

endmodule

// File: rtl/sd_sector_read_ctrl.sv
// Single-sector read cache: serves CPU word reads from a cached SD sector,
// fetching the sector from the SD host on a miss with a bounded wait.
module sd_sector_read_ctrl
  import sd_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned SECTOR_W       = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic [ADDR_W-1:0]      cpu_addr,
  output logic                   cpu_ack,
  output logic [WORD_W-1:0]      cpu_rdata,
  output logic                   cpu_err,
  input  logic                   inv,
  output logic                   sd_rd_start,
  output logic [ADDR_W-1:0]      sd_sector,
  input  logic                   sd_busy,
  input  logic                   sd_done,
  input  logic [SECTOR_BITS-1:0] sd_data
);

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [SECTOR_W-1:0]     sector_q;
  logic [WORD_IDX_W-1:0]   widx_q;
  logic [SECTOR_W-1:0]     tag_q;
  logic                    valid_q;
  logic                    err_pend_q;
  logic [TIMEOUT_W-1:0]    cnt_q;
  logic [SECTOR_BITS-1:0]  buffer_q;
  logic [WORD_W-1:0]       sel_word;

  logic latch_req;
  logic load_sector;
  logic issue;
  logic capture;
  logic timeout;
  logic cnt_inc;
  logic resp;

  // Byte-offset bits carry no information for word reads
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[1:0];

  sd_word_select u_word_select (
    .data_in  (buffer_q),
    .idx      (widx_q),
    .data_out (sel_word)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and control strobes
  always_comb begin
    state_d     = state_q;
    latch_req   = 1'b0;
    load_sector = 1'b0;
    issue       = 1'b0;
    capture     = 1'b0;
    timeout     = 1'b0;
    cnt_inc     = 1'b0;
    resp        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          latch_req = 1'b1;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // A coincident invalidate must not be served from stale data
        if (valid_q && !inv && (tag_q == sector_q)) begin
          state_d = ST_RESP;
        end else begin
          load_sector = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!sd_busy) begin
          issue   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sd_done) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_RESP: begin
        resp    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request, tag/valid, timeout counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sector_q    <= '0;
      widx_q      <= '0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      err_pend_q  <= 1'b0;
      cnt_q       <= '0;
      cpu_ack     <= 1'b0;
      cpu_err     <= 1'b0;
      cpu_rdata   <= '0;
      sd_rd_start <= 1'b0;
      sd_sector   <= '0;
    end else begin
      if (latch_req) begin
        sector_q   <= cpu_addr[9 +: SECTOR_W];
        widx_q     <= cpu_addr[2 +: WORD_IDX_W];
        err_pend_q <= 1'b0;
      end
      if (timeout) err_pend_q <= 1'b1;

      if (capture) tag_q <= sector_q;
      // Invalidate takes priority over a fill landing in the same cycle
      if (inv)          valid_q <= 1'b0;
      else if (capture) valid_q <= 1'b1;
      else if (timeout) valid_q <= 1'b0;

      if (issue)        cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + TIMEOUT_W'(1);

      if (load_sector) sd_sector <= ADDR_W'(sector_q);
      sd_rd_start <= issue;

      cpu_ack <= resp;
      cpu_err <= resp & err_pend_q;
      if (resp) cpu_rdata <= err_pend_q ? '0 : sel_word;
    end
  end

  // Sector buffer has no reset; its content is qualified by valid_q
  always_ff @(posedge clk) begin
    if (capture) buffer_q <= sd_data;
  end

endmodule

// File: tb/tb_sd_sector_read_ctrl.sv
// Scoreboard bench for sd_sector_read_ctrl with a scripted SD host.
module tb_sd_sector_read_ctrl;

  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req;
  logic [31:0]   cpu_addr;
  logic          cpu_ack;
  logic [31:0]   cpu_rdata;
  logic          cpu_err;
  logic          inv;
  logic          sd_rd_start;
  logic [31:0]   sd_sector;
  logic          sd_busy;
  logic          sd_done;
  logic [4095:0] sd_data;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   start_cnt = 0;
  int   ack_cnt   = 0;

  sd_sector_read_ctrl #(.TIMEOUT_CYCLES(TO), .SECTOR_W(23)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .cpu_err     (cpu_err),
    .inv         (inv),
    .sd_rd_start (sd_rd_start),
    .sd_sector   (sd_sector),
    .sd_busy     (sd_busy),
    .sd_done     (sd_done),
    .sd_data     (sd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rev32(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = w[i];
    return r;
  endfunction

  function automatic logic [4095:0] rand_sector();
    logic [4095:0] r;
    for (int i = 0; i < 128; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Scoreboard: every ack pops one expected response
  always @(negedge clk) begin
    exp_t e;
    if (sd_rd_start) start_cnt++;
    if (cpu_ack) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rdata", cpu_rdata, e.rdata);
        check("err", 32'(cpu_err), 32'(e.err));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (cpu_ack) seen = 1'b1;
    end
    cpu_req = 1'b0;
    check(tag, 32'(seen), 32'd1);
  endtask

  // inv_mode: 0 none, 1 inv with sd_done, 2 inv while in CHECK
  task automatic miss_req(input logic [31:0] addr, input logic [4095:0] data,
                          input int busy_n, input int inv_mode);
    logic [6:0] k;
    k = addr[8:2];
    push_exp(rev32(data[32*k +: 32]), 1'b0);
    sd_busy  = (busy_n > 0);
    cpu_addr = addr;
    cpu_req  = 1'b1;
    if (busy_n == 0) begin
      tick(1);
      if (inv_mode == 2) inv = 1'b1;
      tick(1);
      inv = 1'b0;
      check("no_early_start", 32'(sd_rd_start), 32'd0);
      tick(1);
    end else begin
      for (int i = 0; i < busy_n; i++) begin
        tick(1);
        check("busy_no_start", 32'(sd_rd_start), 32'd0);
      end
      sd_busy = 1'b0;
      tick(1);
    end
    check("start", 32'(sd_rd_start), 32'd1);
    check("sector", sd_sector, {9'd0, addr[31:9]});
    cpu_addr = 32'hFFFF_FFFF;
    tick(1);
    check("start_pulse", 32'(sd_rd_start), 32'd0);
    sd_data = data;
    sd_done = 1'b1;
    inv     = (inv_mode == 1);
    tick(1);
    sd_done = 1'b0;
    inv     = 1'b0;
    sd_data = ~data;
    wait_ack("miss_ack");
  endtask

  task automatic hit_req(input logic [31:0] addr, input logic [4095:0] data);
    int s0;
    logic [6:0] k;
    s0 = start_cnt;
    k  = addr[8:2];
    push_exp(rev32(data[32*k +: 32]), 1'b0);
    cpu_addr = addr;
    cpu_req  = 1'b1;
    tick(2);
    check("hit_early", 32'(cpu_ack), 32'd0);
    tick(1);
    check("hit_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    tick(2);
    check("hit_no_start", 32'(start_cnt), 32'(s0));
  endtask

  task automatic to_req(input logic [31:0] addr);
    bit early;
    push_exp(32'd0, 1'b1);
    cpu_addr = addr;
    cpu_req  = 1'b1;
    tick(3);
    check("to_start", 32'(sd_rd_start), 32'd1);
    early = 1'b0;
    for (int i = 1; i < 17; i++) begin
      tick(1);
      if (cpu_ack) early = 1'b1;
    end
    tick(1);
    check("to_early", 32'(early), 32'd0);
    check("to_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    tick(1);
  endtask

  initial begin
    logic [4095:0] d1, d2, d3, d4, d5;
    int a0;
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; inv = 1'b0;
    sd_busy = 1'b0; sd_done = 1'b0; sd_data = '0;
    tick(2);
    check("rst_ack", 32'(cpu_ack), 32'd0);
    check("rst_err", 32'(cpu_err), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_start", 32'(sd_rd_start), 32'd0);
    check("rst_sector", sd_sector, 32'd0);

    // sd_done outside WAIT right after reset is ignored
    rst = 1'b0;
    sd_data = rand_sector();
    sd_done = 1'b1;
    tick(1);
    sd_done = 1'b0;
    tick(2);

    // Cold miss, then hit on the same sector
    d1 = rand_sector();
    d1[63:32] = 32'h0000_0001;
    d1[4095:4064] = 32'h1234_5678;
    miss_req(32'h0000_0204, d1, 0, 0);
    check("cold_word1", cpu_rdata, 32'h8000_0000);
    tick(1);
    hit_req(32'h0000_03FC, d1);
    check("hit_word127", cpu_rdata, 32'h1E6A_2C48);

    // Busy stall on a miss
    d2 = rand_sector();
    miss_req(32'h0000_0A00, d2, 10, 0);
    tick(1);
    hit_req(32'h0000_0A10, d2);

    // Timeout, late sd_done ignored, re-request misses
    to_req(32'h0000_0E08);
    sd_data = rand_sector();
    sd_done = 1'b1;
    tick(1);
    sd_done = 1'b0;
    tick(2);
    d3 = rand_sector();
    miss_req(32'h0000_0E08, d3, 0, 0);
    tick(1);

    // Timeout on another sector drops the cached one
    to_req(32'h0000_1200);
    miss_req(32'h0000_0E0C, d3, 0, 0);
    tick(1);

    // inv with sd_done: data returned, sector not retained
    d4 = rand_sector();
    miss_req(32'h0004_0010, d4, 0, 1);
    miss_req(32'h0004_0014, d4, 0, 0);
    tick(1);
    hit_req(32'h0004_0018, d4);

    // inv while checking forces a miss on a cached sector
    miss_req(32'h0004_001C, d4, 0, 2);
    tick(1);

    // Reset during WAIT abandons the read
    a0 = ack_cnt;
    cpu_addr = 32'h0006_0000;
    cpu_req  = 1'b1;
    tick(3);
    check("rw_start", 32'(sd_rd_start), 32'd1);
    tick(2);
    rst = 1'b1;
    cpu_req = 1'b0;
    tick(2);
    check("rw_sector", sd_sector, 32'd0);
    check("rw_ack", 32'(cpu_ack), 32'd0);
    rst = 1'b0;
    d5 = rand_sector();
    sd_data = d5;
    sd_done = 1'b1;
    tick(1);
    sd_done = 1'b0;
    tick(5);
    check("rw_no_ack", 32'(ack_cnt), 32'(a0));
    miss_req(32'h0004_0018, d4, 0, 0);
    tick(3);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
